// File: rtl/seq_div_32.sv
// -----------------------------------------------------------------------------
// seq_div_32 - multi-cycle restoring shift-subtract divider for RV32M
//              DIV / DIVU / REM / REMU.
//
// One subtract-and-restore step is performed per clock. The pipeline stalls
// while busy is high and picks up result when done pulses.
//
// Ports:
//   clk     in   1      single clock, rising edge
//   rst     in   1      synchronous, active-high reset
//   start   in   1      request; accepted only when busy == 0
//   op      in   2      2'b00 DIV, 2'b01 DIVU, 2'b10 REM, 2'b11 REMU
//   a       in   WIDTH  dividend (rs1)
//   b       in   WIDTH  divisor (rs2)
//   busy    out  1      operation in flight
//   done    out  1      one-cycle pulse: result valid
//   result  out  WIDTH  quotient or remainder; held until the next op finishes
//
// Configuration macro:
//   SEQ_DIV_EARLY_OUT_EN - when defined, a zero divisor or signed overflow
//   seen at accept skips the iterative phase, so done follows one edge after
//   accept. Result values are the same in both builds; only latency differs.
// -----------------------------------------------------------------------------
module seq_div_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] abs_b_r;
  logic [WIDTH-1:0] a_raw_r;
  logic             is_rem_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             div0_r;
  logic             ovf_r;

  // Operand decode at the request: signs, magnitudes and special cases.
  logic             is_signed_s;
  logic             sign_a_s;
  logic             sign_b_s;
  logic [WIDTH-1:0] abs_a_s;
  logic [WIDTH-1:0] abs_b_s;
  logic             div0_s;
  logic             ovf_s;

  // Decode the incoming operands (only meaningful on the accept edge).
  always_comb begin
    is_signed_s = 1'b0;
    sign_a_s    = 1'b0;
    sign_b_s    = 1'b0;
    abs_a_s     = a;
    abs_b_s     = b;
    div0_s      = 1'b0;
    ovf_s       = 1'b0;
    is_signed_s = ~op[0];
    sign_a_s    = is_signed_s & a[WIDTH-1];
    sign_b_s    = is_signed_s & b[WIDTH-1];
    if (sign_a_s) begin
      abs_a_s = ~a + ONE;
    end else begin
      abs_a_s = a;
    end
    if (sign_b_s) begin
      abs_b_s = ~b + ONE;
    end else begin
      abs_b_s = b;
    end
    div0_s = (b == ZERO);
    ovf_s  = is_signed_s && (a == MIN_NEG) && (b == ALL_ONES);
  end

  // One restoring step: shift {rem,quo} left, trial-subtract |b|.
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH+1:0] trial_s;
  logic             trial_ok_s;
  logic [WIDTH-1:0] rem_next_s;
  logic [WIDTH-1:0] quo_next_s;

  // Datapath for a single iteration.
  always_comb begin
    shifted_s  = {rem_r, quo_r[WIDTH-1]};
    trial_s    = {1'b0, shifted_s} - {2'b00, abs_b_r};
    // A non-negative trial is always below |b|, so bit WIDTH is clear
    // whenever the trial succeeds; folding it in keeps the test exact.
    trial_ok_s = ~(trial_s[WIDTH+1] | trial_s[WIDTH]);
    if (trial_ok_s) begin
      rem_next_s = trial_s[WIDTH-1:0];
    end else begin
      rem_next_s = shifted_s[WIDTH-1:0];
    end
    quo_next_s = {quo_r[WIDTH-2:0], trial_ok_s};
  end

  // Final sign fix and special-case override applied in FIN.
  logic [WIDTH-1:0] quo_fix_s;
  logic [WIDTH-1:0] rem_fix_s;
  logic [WIDTH-1:0] final_s;

  // Select the value to register as the result.
  always_comb begin
    if (neg_q_r) begin
      quo_fix_s = ~quo_r + ONE;
    end else begin
      quo_fix_s = quo_r;
    end
    if (neg_r_r) begin
      rem_fix_s = ~rem_r + ONE;
    end else begin
      rem_fix_s = rem_r;
    end
    if (div0_r) begin
      final_s = is_rem_r ? a_raw_r : ALL_ONES;
    end else if (ovf_r) begin
      final_s = is_rem_r ? ZERO : MIN_NEG;
    end else begin
      final_s = is_rem_r ? rem_fix_s : quo_fix_s;
    end
  end

  // Control FSM with registered outputs and the iteration state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= {CW{1'b0}};
      rem_r    <= ZERO;
      quo_r    <= ZERO;
      abs_b_r  <= ZERO;
      a_raw_r  <= ZERO;
      is_rem_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      div0_r   <= 1'b0;
      ovf_r    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            rem_r    <= ZERO;
            quo_r    <= abs_a_s;
            abs_b_r  <= abs_b_s;
            a_raw_r  <= a;
            is_rem_r <= op[1];
            neg_q_r  <= sign_a_s ^ sign_b_s;
            neg_r_r  <= sign_a_s;
            div0_r   <= div0_s;
            ovf_r    <= ovf_s;
            cnt_r    <= CW'(WIDTH);
            busy     <= 1'b1;
`ifdef SEQ_DIV_EARLY_OUT_EN
            state_r  <= (div0_s | ovf_s) ? FIN : CALC;
`else
            state_r  <= CALC;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          done  <= 1'b0;
          rem_r <= rem_next_s;
          quo_r <= quo_next_s;
          cnt_r <= cnt_r - CNT_ONE;
          // The edge that takes the counter to zero also moves to FIN.
          if (cnt_r == CNT_ONE) begin
            state_r <= FIN;
          end else begin
            state_r <= CALC;
          end
        end
        FIN: begin
          result  <= final_s;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_32.sv
module tb_seq_div_32;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int errors = 0;
  int checks = 0;

  seq_div_32 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model from the ISA rules, using plain signed/unsigned arithmetic.
  function automatic logic [W-1:0] ref_div(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [W-1:0] sx;
    logic signed [W-1:0] sy;
    sx = x;
    sy = y;
    if (y == 32'h0000_0000) return (o[1] ? x : 32'hFFFF_FFFF);
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
      return (o[1] ? 32'h0000_0000 : 32'h8000_0000);
    case (o)
      2'b00:   return sx / sy;
      2'b01:   return x / y;
      2'b10:   return sx % sy;
      default: return x % y;
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    bit special;
    special = (y == 32'h0000_0000) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
`ifdef SEQ_DIV_EARLY_OUT_EN
    return special ? 1 : W + 1;
`else
    return (special && 1'b0) ? 1 : W + 1;
`endif
  endfunction

  // Waits for done, counting edges since the accept edge; lat=0 on timeout.
  task automatic wait_done(input int already, output logic [W-1:0] res, output int lat);
    lat = 0;
    res = 32'h0000_0000;
    for (int i = already + 1; i <= already + 100; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        res = result;
        break;
      end
    end
  endtask

  // Issues one op, scrambles operands after accept, and waits for done.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] res, output int lat);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 2'($urandom_range(0, 3));
    wait_done(0, res, lat);
  endtask

  initial begin
    logic [W-1:0] res;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [1:0]   o;
    int           lat;
    int           pulses;

    vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14};
    vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2};
    vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
    vecs[4]  = '{2'b01, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF};
    vecs[5]  = '{2'b10, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9};
    vecs[6]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    vecs[7]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000};
    vecs[8]  = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
    vecs[9]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1};
    vecs[10] = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
    vecs[11] = '{2'b11, 32'hFFFF_FFFF,  32'd16,         32'd15};
    vecs[12] = '{2'b01, 32'd5,          32'd9,          32'd0};
    vecs[13] = '{2'b11, 32'd5,          32'd9,          32'd5};
    vecs[14] = '{2'b00, 32'd0,          32'd0,          32'hFFFF_FFFF};

    rst = 1'b1; start = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table.
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check_int($sformatf("vec%0d_latency", i), lat, exp_lat(vecs[i].op, vecs[i].a, vecs[i].b));
    end

    // Start while busy must not disturb the op in flight.
    @(negedge clk);
    op = 2'b01; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_accept", {31'b0, busy}, 32'h1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    op = 2'b00; a = 32'd50; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(10, res, lat);
    check("start_while_busy_result", res, 32'd142);
    check_int("start_while_busy_latency", lat, W + 1);

    // Reset mid-operation aborts with no done.
    @(negedge clk);
    op = 2'b11; a = 32'd999; b = 32'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_done", {31'b0, done}, 32'h0);
    check("abort_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check_int("abort_no_done", pulses, 0);

    // Back-to-back: start in the cycle done is high.
    run_op(2'b01, 32'd200, 32'd9, res, lat);
    check("b2b_first_result", res, 32'd22);
    op = 2'b10; a = 32'hFFFF_FF9C; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_accept_busy", {31'b0, busy}, 32'h1);
    check("b2b_done_one_cycle", {31'b0, done}, 32'h0);
    check("b2b_result_held", result, 32'd22);
    wait_done(0, res, lat);
    check("b2b_second_result", res, 32'hFFFF_FFFE);
    check_int("b2b_second_latency", lat, W + 1);

    // Randomized compare against the reference model.
    for (int n = 0; n < 1000; n++) begin
      int mode;
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      mode = $urandom_range(0, 9);
      if (mode == 0) y = 32'h0;
      else if (mode == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      else if (mode == 2) y = 32'($urandom_range(1, 15));
      else if (mode == 3) y = ~32'($urandom_range(0, 15));
      run_op(o, x, y, res, lat);
      check($sformatf("rand%0d_op%0d_%h_%h", n, o, x, y), res, ref_div(o, x, y));
      check_int($sformatf("rand%0d_latency", n), lat, exp_lat(o, x, y));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
